// File: rtl/mem_image_writer.sv
// -----------------------------------------------------------------------------
// mem_image_writer
//
// Loads one IN_WIDTH-byte input vector into the byte-addressed input RAM that
// feeds the network. A start strobe in IDLE captures the whole vector and its
// base address. The block then writes one byte per clock at consecutive
// addresses, wrapping modulo 2^ADDR_W, and pulses done for one cycle.
//
// Optional feature (macro MEM_WRITE_VERIFY_EN):
//   After the writes, every byte is read back through the synchronous RAM
//   (1-cycle read latency) and compared with the captured vector. A mismatch
//   sets the sticky verify_err flag. An accepted start or reset clears it.
//   With the macro undefined, mem_rdata is ignored and verify_err is tied 0.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      write request, sampled only in IDLE
//   base_addr  first byte address, captured with start
//   data_in    vector to write, captured with start; data_in[0] -> base_addr
//   busy       high whenever the writer is not idle
//   done       one-cycle completion pulse
//   next_addr  captured base + IN_WIDTH (mod 2^ADDR_W), held until next capture
//   mem_we     RAM write enable
//   mem_addr   RAM address
//   mem_wdata  RAM write data
//   mem_rdata  RAM read data (read-back only)
//   verify_err sticky read-back mismatch flag
// -----------------------------------------------------------------------------
module mem_image_writer #(
  parameter int IN_WIDTH = 2,
  parameter int ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        data_in [IN_WIDTH],
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] next_addr,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              verify_err
);

  // The index must also reach IN_WIDTH for the final read-back step.
  localparam int IDX_W = $clog2(IN_WIDTH + 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(IN_WIDTH - 1);
  localparam logic [IDX_W-1:0] VERIFY_END = IDX_W'(IN_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_VERIFY = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t            state_r;
  logic [IDX_W-1:0]  idx_r;
  logic [ADDR_W-1:0] base_r;
  logic [7:0]        buf_r [IN_WIDTH];
  logic              busy_r;
  logic              done_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [7:0]        mem_wdata_r;
  logic [ADDR_W-1:0] next_addr_r;

  // Byte selection by comparison, so the index width never has to match the
  // array depth exactly.
  function automatic logic [7:0] pick_byte(input logic [7:0] vec [IN_WIDTH],
                                           input logic [IDX_W-1:0] k);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < IN_WIDTH; i++) begin
      if (k == IDX_W'(i)) begin
        r = vec[i];
      end
    end
    return r;
  endfunction

`ifdef MEM_WRITE_VERIFY_EN
  // Two-stage compare pipeline. Stage 1 marks the cycle an address is on the
  // bus. Stage 2 marks the cycle the RAM returns that byte.
  logic             pend1_v_r;
  logic [IDX_W-1:0] pend1_k_r;
  logic             pend2_v_r;
  logic [IDX_W-1:0] pend2_k_r;
  logic             verify_err_r;
`endif

  // Control FSM with registered outputs. The outputs trail the state register
  // by one edge, so the first write appears one cycle after capture. DONE
  // spans two edges: one for the last write/read-back, one for the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      idx_r       <= '0;
      base_r      <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= 8'h00;
      next_addr_r <= '0;
      for (int i = 0; i < IN_WIDTH; i++) begin
        buf_r[i] <= 8'h00;
      end
`ifdef MEM_WRITE_VERIFY_EN
      pend1_v_r    <= 1'b0;
      pend1_k_r    <= '0;
      pend2_v_r    <= 1'b0;
      pend2_k_r    <= '0;
      verify_err_r <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          mem_we_r <= 1'b0;
          done_r   <= 1'b0;
          if (start) begin
            for (int i = 0; i < IN_WIDTH; i++) begin
              buf_r[i] <= data_in[i];
            end
            base_r      <= base_addr;
            next_addr_r <= base_addr + ADDR_W'(IN_WIDTH);
            idx_r       <= '0;
            busy_r      <= 1'b1;
            state_r     <= ST_WRITE;
`ifdef MEM_WRITE_VERIFY_EN
            verify_err_r <= 1'b0;
`endif
          end else begin
            busy_r <= 1'b0;
          end
        end

        ST_WRITE: begin
          mem_we_r    <= 1'b1;
          mem_addr_r  <= base_r + ADDR_W'(idx_r);
          mem_wdata_r <= pick_byte(buf_r, idx_r);
          if (idx_r == LAST_IDX) begin
            idx_r <= '0;
`ifdef MEM_WRITE_VERIFY_EN
            state_r <= ST_VERIFY;
`else
            state_r <= ST_DONE;
`endif
          end else begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end

`ifdef MEM_WRITE_VERIFY_EN
        // IN_WIDTH address cycles plus one trailing cycle for the pipeline.
        ST_VERIFY: begin
          mem_we_r <= 1'b0;
          if (idx_r != VERIFY_END) begin
            mem_addr_r <= base_r + ADDR_W'(idx_r);
            pend1_v_r  <= 1'b1;
            pend1_k_r  <= idx_r;
            idx_r      <= idx_r + IDX_W'(1);
          end else begin
            pend1_v_r <= 1'b0;
            idx_r     <= '0;
            state_r   <= ST_DONE;
          end
        end
`endif

        ST_DONE: begin
          mem_we_r <= 1'b0;
          if (!done_r) begin
            done_r <= 1'b1;
            busy_r <= 1'b1;
          end else begin
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end

        default: begin
          state_r  <= ST_IDLE;
          mem_we_r <= 1'b0;
          done_r   <= 1'b0;
          busy_r   <= 1'b0;
        end
      endcase

`ifdef MEM_WRITE_VERIFY_EN
      // mem_rdata now holds the byte addressed two edges ago.
      pend2_v_r <= pend1_v_r;
      pend2_k_r <= pend1_k_r;
      if (pend2_v_r && (mem_rdata != pick_byte(buf_r, pend2_k_r))) begin
        verify_err_r <= 1'b1;
      end else begin
        verify_err_r <= verify_err_r & ~(state_r == ST_IDLE && start);
      end
`endif
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign next_addr = next_addr_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;

`ifdef MEM_WRITE_VERIFY_EN
  assign verify_err = verify_err_r;
`else
  logic unused_rdata_s;
  assign unused_rdata_s = ^mem_rdata;
  assign verify_err     = 1'b0;
`endif

endmodule

// File: tb/tb_mem_image_writer.sv
// -----------------------------------------------------------------------------
// Testbench for mem_image_writer. Two instances are used: a 2-byte writer for
// most scenarios and a 4-byte writer for the mid-write reset case. Each
// instance has its own behavioural synchronous RAM. The expected writes,
// addresses and latencies come from the vector/base rules, computed here.
// -----------------------------------------------------------------------------
module tb_mem_image_writer;

  localparam int N2 = 2;
  localparam int N4 = 4;
  // Edge (counted from the start-sampling edge) at which done becomes visible.
`ifdef MEM_WRITE_VERIFY_EN
  localparam int LAT2 = N2 + 1 + (N2 + 1);
  localparam int LAT4 = N4 + 1 + (N4 + 1);
`else
  localparam int LAT2 = N2 + 1;
  localparam int LAT4 = N4 + 1;
`endif

  logic clk = 1'b0;
  logic rst_n;

  logic       start2, busy2, done2, we2, verr2;
  logic [7:0] base2, next2, addr2, wdata2, rdata2;
  logic [7:0] din2 [N2];

  logic       start4, busy4, done4, we4, verr4;
  logic [7:0] base4, next4, addr4, wdata4, rdata4;
  logic [7:0] din4 [N4];

  logic [7:0]  ram2 [256];
  logic [7:0]  ram4 [256];
  logic [15:0] wq2 [$];
  logic [15:0] wq4 [$];
  logic        corrupt_en;
  logic [7:0]  corrupt_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_image_writer #(.IN_WIDTH(N2), .ADDR_W(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .base_addr(base2),
    .data_in(din2), .busy(busy2), .done(done2), .next_addr(next2),
    .mem_we(we2), .mem_addr(addr2), .mem_wdata(wdata2),
    .mem_rdata(rdata2), .verify_err(verr2)
  );

  mem_image_writer #(.IN_WIDTH(N4), .ADDR_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .base_addr(base4),
    .data_in(din4), .busy(busy4), .done(done4), .next_addr(next4),
    .mem_we(we4), .mem_addr(addr4), .mem_wdata(wdata4),
    .mem_rdata(rdata4), .verify_err(verr4)
  );

  // RAM models: synchronous write and read, optional corruption on read.
  always @(posedge clk) begin
    if (we2) begin
      ram2[addr2] <= wdata2;
      wq2.push_back({addr2, wdata2});
    end
    rdata2 <= (corrupt_en && addr2 == corrupt_addr) ? ~ram2[addr2] : ram2[addr2];
    if (we4) begin
      ram4[addr4] <= wdata4;
      wq4.push_back({addr4, wdata4});
    end
    rdata4 <= ram4[addr4];
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for done on the 2-byte writer; returns edges waited.
  task automatic wait_done2(output int k);
    bit got;
    k = 0; got = 1'b0;
    while (!got && k < 100) begin
      @(negedge clk); k++; got = done2;
    end
  endtask

  // One complete 2-byte operation checked against the write rules.
  task automatic run2(input logic [7:0] b, input logic [7:0] d0, input logic [7:0] d1,
                      input bit disturb, input logic exp_verr);
    logic [7:0] d [2];
    logic [7:0] a, exp_next;
    int k;
    bit got;
    d[0] = d0; d[1] = d1;
    exp_next = b + 8'd2;
    @(negedge clk);
    wq2.delete();
    base2 = b; din2[0] = d0; din2[1] = d1; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    check_val("busy_after_start", busy2, 1);
    k = 0; got = 1'b0;
    while (!got && k < 100) begin
      if (disturb && k < 2) begin
        start2 = 1'b1; din2[0] = ~d0; din2[1] = d0 ^ 8'h5A; base2 = b + 8'd7;
      end else begin
        start2 = 1'b0;
      end
      @(negedge clk); k++; got = done2;
    end
    check_val("done_latency", k, LAT2);
    check_val("busy_with_done", busy2, 1);
    check_val("next_addr", next2, exp_next);
    check_val("verify_err_at_done", verr2, exp_verr);
    check_val("write_count", wq2.size(), 2);
    for (int i = 0; i < 2; i++) begin
      if (i < wq2.size()) begin
        a = b + 8'(i);
        check_val("wr_addr", wq2[i][15:8], a);
        check_val("wr_data", wq2[i][7:0], d[i]);
        check_val("ram_readback", ram2[a], d[i]);
      end
    end
    @(negedge clk);
    check_val("done_one_cycle", done2, 0);
    check_val("idle_after_done", busy2, 0);
    check_val("no_write_after_done", wq2.size(), 2);
  endtask

  initial begin
    int k;
    bit got;
    logic [7:0] rb, r0, r1;
    logic [7:0] d4 [N4];

    rst_n = 1'b0; corrupt_en = 1'b0; corrupt_addr = 8'h00;
    start2 = 1'b0; base2 = 8'h00; din2[0] = 8'h00; din2[1] = 8'h00;
    start4 = 1'b0; base4 = 8'h00;
    for (int i = 0; i < N4; i++) din4[i] = 8'h00;
    repeat (3) @(negedge clk);
    check_val("rst_busy", busy2, 0);
    check_val("rst_done", done2, 0);
    check_val("rst_we", we2, 0);
    check_val("rst_addr", addr2, 0);
    check_val("rst_wdata", wdata2, 0);
    check_val("rst_next", next2, 0);
    check_val("rst_verr", verr2, 0);
    rst_n = 1'b1;

    // Idle with start low: nothing may be written.
    repeat (20) @(negedge clk);
    check_val("idle_no_writes2", wq2.size(), 0);
    check_val("idle_no_writes4", wq4.size(), 0);
    check_val("idle_busy", busy2, 0);
    check_val("idle_done", done2, 0);

    // Directed vectors, including address wrap and start/data during WRITE.
    run2(8'h10, 8'hA5, 8'h3C, 1'b0, 1'b0);
    check_val("reader_0x10", ram2[8'h10], 8'hA5);
    check_val("reader_0x11", ram2[8'h11], 8'h3C);
    run2(8'hFF, 8'h01, 8'h02, 1'b0, 1'b0);
    run2(8'h30, 8'hC3, 8'h7E, 1'b1, 1'b0);

    // Randomized vectors.
    for (int t = 0; t < 8; t++) begin
      rb = 8'($urandom_range(0, 255));
      r0 = 8'($urandom);
      r1 = 8'($urandom);
      run2(rb, r0, r1, t[0], 1'b0);
    end

    // Back-to-back: start held through DONE is taken after one idle cycle.
    @(negedge clk);
    wq2.delete();
    base2 = 8'h20; din2[0] = 8'h11; din2[1] = 8'h22; start2 = 1'b1;
    wait_done2(k);
    check_val("b2b_first_done", k, LAT2 + 1);
    @(negedge clk);
    check_val("b2b_idle_gap", busy2, 0);
    @(negedge clk);
    check_val("b2b_accept", busy2, 1);
    start2 = 1'b0;
    wait_done2(k);
    check_val("b2b_second_done", k, LAT2);
    check_val("b2b_writes", wq2.size(), 4);

    // Reset during a 4-byte write: only the first byte may land.
    @(negedge clk);
    wq4.delete();
    base4 = 8'h80;
    for (int i = 0; i < N4; i++) begin
      d4[i] = 8'($urandom);
      din4[i] = d4[i];
    end
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    check_val("r4_first_we", we4, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("r4_async_we", we4, 0);
    check_val("r4_async_busy", busy4, 0);
    check_val("r4_async_addr", addr4, 0);
    check_val("r4_async_wdata", wdata4, 0);
    check_val("r4_async_next", next4, 0);
    check_val("r4_async_done", done4, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_val("r4_write_count", wq4.size(), 1);
    if (wq4.size() > 0) begin
      check_val("r4_write_addr", wq4[0][15:8], 8'h80);
      check_val("r4_write_data", wq4[0][7:0], d4[0]);
    end

    // Fresh 4-byte operation after reset.
    @(negedge clk);
    wq4.delete();
    base4 = 8'hFE;
    for (int i = 0; i < N4; i++) begin
      d4[i] = 8'($urandom);
      din4[i] = d4[i];
    end
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    k = 0; got = 1'b0;
    while (!got && k < 100) begin
      @(negedge clk); k++; got = done4;
    end
    check_val("r4_done_latency", k, LAT4);
    check_val("r4_next_addr", next4, 8'h02);
    check_val("r4_verify_err", verr4, 0);
    check_val("r4_new_writes", wq4.size(), N4);
    for (int i = 0; i < N4; i++) begin
      if (i < wq4.size()) begin
        rb = 8'hFE + 8'(i);
        check_val("r4_wr_addr", wq4[i][15:8], rb);
        check_val("r4_wr_data", wq4[i][7:0], d4[i]);
      end
    end

`ifdef MEM_WRITE_VERIFY_EN
    // Corrupted read-back at base+1 flags an error; the next clean run clears it.
    corrupt_en = 1'b1; corrupt_addr = 8'h41;
    run2(8'h40, 8'h12, 8'h34, 1'b0, 1'b1);
    corrupt_en = 1'b0;
    run2(8'h50, 8'h56, 8'h78, 1'b0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
